// File: rtl/gfx_dual_port_ram.sv
// -----------------------------------------------------------------------------
// gfx_dual_port_ram
//
// Purpose:
//   True dual-port word RAM with per-byte write enables, a built-in clear
//   engine that fills every location with INIT_VAL after reset or on request,
//   out-of-range access flagging and a selectable cross-port
//   read-during-write policy.
//
// Ports:
//   clk, rst_n               single clock, asynchronous active-low reset
//   en_a/en_b                access request for port A / B
//   we_a/we_b                1 = write, 0 = read
//   be_a/be_b                byte enables for writes (DATA_W/8 bits)
//   addr_a/addr_b            word address (ADDR_W bits)
//   wdata_a/wdata_b          write data
//   rdata_a/rdata_b          registered read data, held when no read returns
//   rvalid_a/rvalid_b        rdata valid this cycle (1-cycle read latency)
//   oor_a/oor_b              one-cycle pulse for an out-of-range access
//   clear_req                starts a full memory clear when idle
//   busy                     clear engine running, port requests ignored
// -----------------------------------------------------------------------------
module gfx_dual_port_ram #(
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 300,
  parameter int              ADDR_W   = 9,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit              RDW_NEW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   wdata_a,
  output logic [DATA_W-1:0]   rdata_a,
  output logic                rvalid_a,
  output logic                oor_a,

  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   wdata_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                rvalid_b,
  output logic                oor_b,

  input  logic                clear_req,
  output logic                busy
);

  localparam int NB = DATA_W / 8;

  // One extra bit so the range compare still works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              acc_a, acc_b;
  logic              inr_a, inr_b;
  logic              wr_a, wr_b;
  logic              rd_a, rd_b;
  logic              same_addr;

  logic [DATA_W-1:0] rdata_a_d, rdata_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
  logic              rvalid_a_q, rvalid_b_q;
  logic              oor_a_q, oor_b_q;

  // Overlay the enabled bytes of a write onto an existing word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [NB-1:0]     be,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign busy = (state_q == ST_CLEAR);

  // Port qualification. Requests are only accepted while the clear engine is
  // idle; out-of-range writes are accepted (so they can flag oor) but dropped.
  assign acc_a     = en_a & ~busy;
  assign acc_b     = en_b & ~busy;
  assign inr_a     = ({1'b0, addr_a} < DEPTH_C);
  assign inr_b     = ({1'b0, addr_b} < DEPTH_C);
  assign wr_a      = acc_a & we_a & inr_a;
  assign wr_b      = acc_b & we_b & inr_b;
  assign rd_a      = acc_a & ~we_a;
  assign rd_b      = acc_b & ~we_b;
  assign same_addr = (addr_a == addr_b);

  // Clear engine: walks the counter 0..DEPTH-1, then drops back to idle.
  // A clear request that arrives while already clearing is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (clear_req) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory array, intentionally without reset. Clear writes and port writes
  // never overlap since ports are locked out while busy. On a same-address
  // collision port A's enabled bytes take priority over port B's.
  always_ff @(posedge clk) begin
    if (busy) begin
      if (rst_n) mem[cnt_q] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_a && be_a[i]) begin
          mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
        end
        if (wr_b && be_b[i] && !(wr_a && same_addr && be_a[i])) begin
          mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
        end
      end
    end
  end

  // Read data selection. The array read naturally returns pre-write data;
  // with RDW_NEW the other port's same-cycle write is folded in so the reader
  // sees the merged post-write word. Out-of-range reads return zero.
  always_comb begin
    rdata_a_d = '0;
    if (inr_a) begin
      rdata_a_d = mem[addr_a];
      if (RDW_NEW && wr_b && same_addr) begin
        rdata_a_d = merge_bytes(rdata_a_d, be_b, wdata_b);
      end
    end
  end

  always_comb begin
    rdata_b_d = '0;
    if (inr_b) begin
      rdata_b_d = mem[addr_b];
      if (RDW_NEW && wr_a && same_addr) begin
        rdata_b_d = merge_bytes(rdata_b_d, be_a, wdata_a);
      end
    end
  end

  // Output registers. rdata only loads on an accepted read so it holds its
  // last value otherwise; oor pulses for any accepted out-of-range access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      oor_a_q    <= 1'b0;
      oor_b_q    <= 1'b0;
    end else begin
      rvalid_a_q <= rd_a;
      rvalid_b_q <= rd_b;
      oor_a_q    <= acc_a & ~inr_a;
      oor_b_q    <= acc_b & ~inr_b;
      if (rd_a) rdata_a_q <= rdata_a_d;
      if (rd_b) rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign oor_a    = oor_a_q;
  assign oor_b    = oor_b_q;

endmodule
